// File: rtl/seq_ctrl.sv
// ----------------------------------------------------------------------------
// seq_ctrl
// Multi-cycle instruction sequencer for the NPC core. Owns the PC and walks a
// single instruction at a time through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
//
// Ports
//   clk, rst        core clock (rising edge), async active-high reset
//   opcode_i        opcode from the decoder (combinational from inst_o)
//   func3_i         func3 from the decoder
//   imem_req_o      instruction fetch request (decoded from state)
//   imem_addr_o     fetch address, always equal to pc_o
//   imem_ack_i      fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i    fetched instruction word
//   inst_o          latched instruction for the decoder
//   pc_o            current PC for decoder/exu
//   dmem_req_o      data access request (decoded from state)
//   dmem_we_o       1 = store, 0 = load; qualified by dmem_req_o
//   dmem_ack_i      data access complete
//   br_taken_i      branch condition from exu
//   target_i        branch/jal/jalr target from exu
//   rf_we_o         register-file write enable, one-cycle pulse in WB
//   retire_o        one-cycle pulse in WB when an instruction completes
//   halt_o          sticky, ebreak reached
//   err_o           sticky, memory timeout or misaligned next PC
//   state_o         current state for debug/difftest
// ----------------------------------------------------------------------------
module seq_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  func3_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    input  logic        br_taken_i,
    input  logic [63:0] target_i,
    output logic        rf_we_o,
    output logic        retire_o,
    output logic        halt_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ILEN-1:0]  INST_NOP  = 32'h0000_0013;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    state_e           state_q,  state_d;
    logic [XLEN-1:0]  pc_q,     pc_d;
    logic [XLEN-1:0]  npc_q,    npc_d;
    logic [ILEN-1:0]  inst_q,   inst_d;
    logic [OP_W-1:0]  op_q,     op_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             misal_q,  misal_d;
    logic             rf_we_q,  rf_we_d;
    logic             retire_q, retire_d;
    logic             halt_q,   halt_d;
    logic             err_q,    err_d;

    logic             is_store;
    logic             is_mem;
    logic             writes_rd;
    logic             is_ebreak;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  npc_sel;

    // Opcode is captured in DECODE so later states do not depend on the decoder.
    assign is_store  = (op_q == OP_STORE);
    assign is_mem    = (op_q == OP_LOAD) || is_store;
    assign writes_rd = !(is_store || (op_q == OP_BRANCH) || (op_q == OP_SYSTEM));
    assign is_ebreak = (opcode_i == OP_SYSTEM) && (func3_i == 3'b000) && inst_q[20];
    assign pc_plus4  = pc_q + XLEN'(4);
    assign npc_sel   = ((op_q == OP_JAL) || (op_q == OP_JALR) ||
                        ((op_q == OP_BRANCH) && br_taken_i)) ? target_i : pc_plus4;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        npc_d    = npc_q;
        inst_d   = inst_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        misal_d  = misal_q;
        rf_we_d  = 1'b0;
        retire_d = 1'b0;
        halt_d   = halt_q;
        err_d    = err_q;

        case (state_q)
            S_FETCH: begin
                // An ack on the terminal count still wins over the timeout.
                if (imem_ack_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = S_DECODE;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode_i;
                if (is_ebreak) begin
                    state_d = S_HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    // WB pulses are registered, so the next PC is resolved here.
                    // A misaligned target traps: no retire and no write-back.
                    state_d  = S_WB;
                    npc_d    = npc_sel;
                    misal_d  = |npc_sel[1:0];
                    retire_d = ~(|npc_sel[1:0]);
                    rf_we_d  = writes_rd && ~(|npc_sel[1:0]);
                end
            end
            S_MEM: begin
                if (dmem_ack_i) begin
                    state_d  = S_WB;
                    npc_d    = pc_plus4;
                    misal_d  = |pc_plus4[1:0];
                    retire_d = ~(|pc_plus4[1:0]);
                    rf_we_d  = writes_rd && ~(|pc_plus4[1:0]);
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                if (misal_q) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    pc_d    = npc_q;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            S_ERR:  state_d = S_ERR;
            default: begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_RESET;
            npc_q    <= PC_RESET;
            inst_q   <= INST_NOP;
            op_q     <= INST_NOP[OP_W-1:0];
            cnt_q    <= '0;
            misal_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            retire_q <= 1'b0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            inst_q   <= inst_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            misal_q  <= misal_d;
            rf_we_q  <= rf_we_d;
            retire_q <= retire_d;
            halt_q   <= halt_d;
            err_q    <= err_d;
        end
    end

    // Request strobes are state decodes; the fetch request is gated off in reset.
    assign imem_req_o  = (state_q == S_FETCH) && !rst;
    assign imem_addr_o = pc_q;
    assign dmem_req_o  = (state_q == S_MEM);
    assign dmem_we_o   = (state_q == S_MEM) && is_store;

    assign inst_o   = inst_q;
    assign pc_o     = pc_q;
    assign rf_we_o  = rf_we_q;
    assign retire_o = retire_q;
    assign halt_o   = halt_q;
    assign err_o    = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_ctrl
// Scoreboard bench for seq_ctrl: each scenario pushes its expected events
// (fetch start, data access, retire, halt, error) with the cycle they must
// appear in; a negedge monitor pops and compares whenever the DUT shows one.
// ----------------------------------------------------------------------------
module tb_seq_ctrl;

    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [63:0] RET_WR = 64'h13;  // {state=WB, retire=1, rf_we=1}
    localparam logic [63:0] RET_NW = 64'h12;  // {state=WB, retire=1, rf_we=0}
    localparam logic [63:0] ST_FETCH = 64'd0;
    localparam logic [63:0] ST_HALT  = 64'd5;
    localparam logic [63:0] ST_ERR   = 64'd6;

    localparam logic [31:0] I_ADDI   = 32'h0010_0093;
    localparam logic [31:0] I_SD     = 32'h0010_3023;
    localparam logic [31:0] I_LD     = 32'h0000_3083;
    localparam logic [31:0] I_BEQ    = 32'h0000_0063;
    localparam logic [31:0] I_JAL    = 32'h0000_00EF;
    localparam logic [31:0] I_JALR   = 32'h0000_00E7;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_ECALL  = 32'h0000_0073;

    typedef enum int {EV_FETCH, EV_DMEM, EV_RETIRE, EV_HALT, EV_ERR} ev_e;
    typedef struct {
        ev_e         kind;
        int          cyc;
        logic [63:0] d0;
        logic [63:0] d1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode_i;
    logic [2:0]  func3_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ack_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [63:0] target_i = 64'h0;
    logic        rf_we_o;
    logic        retire_o;
    logic        halt_o;
    logic        err_o;
    logic [2:0]  state_o;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Memory model configuration (one-word program at BASE).
    int          plen  = 0;
    logic [31:0] prog0 = NOP;
    int          iwait = 0;
    int          dwait = 0;
    logic        spur  = 1'b0;

    // Decoder model.
    assign opcode_i = inst_o[6:0];
    assign func3_i  = inst_o[14:12];

    seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode_i),
        .func3_i      (func3_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_ack_i   (dmem_ack_i),
        .br_taken_i   (br_taken_i),
        .target_i     (target_i),
        .rf_we_o      (rf_we_o),
        .retire_o     (retire_o),
        .halt_o       (halt_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    function automatic void push(input ev_e k, input int c, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e.kind = k; e.cyc = c; e.d0 = a; e.d1 = b;
        q.push_back(e);
    endfunction

    // Memory responder: acks after a configurable number of wait cycles.
    int iw = 0;
    int dw = 0;
    always @(negedge clk) begin
        if (rst) begin
            imem_ack_i = 1'b0;
            dmem_ack_i = 1'b0;
            iw = 0;
            dw = 0;
        end else begin
            imem_ack_i = 1'b0;
            if (imem_req_o) begin
                if (iw == iwait && plen == 1 && imem_addr_o == BASE) begin
                    imem_ack_i   = 1'b1;
                    imem_rdata_i = prog0;
                    iw = 0;
                end else begin
                    iw++;
                end
            end
            dmem_ack_i = spur;
            if (dmem_req_o) begin
                if (dw == dwait) begin
                    dmem_ack_i = 1'b1;
                    dw = 0;
                end else begin
                    dw++;
                end
            end
        end
    end

    // Monitor / scoreboard.
    int          cyc = 0;
    logic        pv_ireq = 1'b0, pv_dreq = 1'b0, pv_halt = 1'b0, pv_err = 1'b0;
    logic [63:0] pv_iaddr = 64'h0;
    int          dheld = 0;
    logic        dwe_any = 1'b0, dwe_all = 1'b1;

    task automatic expect_ev(input ev_e k, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL unexpected %s at cycle %0d: got d0=0x%0h d1=0x%0h, expected no event",
                     k.name(), cyc, a, b);
            return;
        end
        e = q.pop_front();
        if (e.kind == k && e.cyc == cyc && e.d0 === a && e.d1 === b) n_pass++;
        else $display("FAIL event %s: got %s cyc=%0d d0=0x%0h d1=0x%0h, expected %s cyc=%0d d0=0x%0h d1=0x%0h",
                      e.kind.name(), k.name(), cyc, a, b, e.kind.name(), e.cyc, e.d0, e.d1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            pv_ireq = 1'b0; pv_dreq = 1'b0; pv_halt = 1'b0; pv_err = 1'b0;
            chk("reset ctl", 64'({imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, retire_o, halt_o, err_o}), 64'd0);
            chk("reset pc", pc_o, BASE);
            chk("reset inst", 64'(inst_o), 64'(NOP));
            chk("reset state", 64'(state_o), ST_FETCH);
        end else begin
            cyc++;
            if (dmem_req_o) begin
                if (!pv_dreq) begin dheld = 0; dwe_any = 1'b0; dwe_all = 1'b1; end
                dheld++;
                dwe_any |= dmem_we_o;
                dwe_all &= dmem_we_o;
            end else if (pv_dreq) begin
                expect_ev(EV_DMEM, 64'(dheld), 64'({dwe_any, dwe_all}));
            end
            if (retire_o || rf_we_o)
                expect_ev(EV_RETIRE, pc_o, 64'({state_o, retire_o, rf_we_o}));
            if (imem_req_o && !pv_ireq)
                expect_ev(EV_FETCH, imem_addr_o, 64'(state_o));
            if (imem_req_o && pv_ireq)
                chk("imem addr hold", imem_addr_o, pv_iaddr);
            if (halt_o && !pv_halt) expect_ev(EV_HALT, pc_o, 64'(state_o));
            if (err_o && !pv_err)   expect_ev(EV_ERR, pc_o, 64'(state_o));
            pv_ireq  = imem_req_o;
            pv_iaddr = imem_addr_o;
            pv_dreq  = dmem_req_o;
            pv_halt  = halt_o;
            pv_err   = err_o;
        end
    end

    task automatic drain(input string nm, input int budget);
        int i;
        i = 0;
        while (q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_chk++;
        if (q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s drain: got %0d pending events after %0d cycles, expected 0", nm, q.size(), budget);
            q.delete();
        end
    endtask

    // Entered and left with rst asserted; release lands just after a posedge.
    task automatic run(input string nm, input int pl, input logic [31:0] inst,
                       input int iwt, input int dwt, input logic bt,
                       input logic [63:0] tg, input logic sp);
        plen = pl; prog0 = inst; iwait = iwt; dwait = dwt;
        br_taken_i = bt; target_i = tg; spur = sp;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drain(nm, 400);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;

        // addi, zero-wait fetch, stray dmem acks ignored
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_RETIRE, 4, BASE, RET_WR);
        push(EV_FETCH, 5, BASE + 64'd4, ST_FETCH);
        run("addi", 1, I_ADDI, 0, 0, 1'b0, 64'h0, 1'b1);

        // sd with three dmem wait cycles
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_DMEM, 8, 64'd4, 64'd3);
        push(EV_RETIRE, 8, BASE, RET_NW);
        push(EV_FETCH, 9, BASE + 64'd4, ST_FETCH);
        run("sd", 1, I_SD, 0, 3, 1'b0, 64'h0, 1'b0);

        // ld, zero-wait
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_DMEM, 5, 64'd1, 64'd0);
        push(EV_RETIRE, 5, BASE, RET_WR);
        push(EV_FETCH, 6, BASE + 64'd4, ST_FETCH);
        run("ld", 1, I_LD, 0, 0, 1'b0, 64'h0, 1'b0);

        // beq taken / not taken
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_RETIRE, 4, BASE, RET_NW);
        push(EV_FETCH, 5, 64'h8000_0100, ST_FETCH);
        run("beq taken", 1, I_BEQ, 0, 0, 1'b1, 64'h8000_0100, 1'b0);

        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_RETIRE, 4, BASE, RET_NW);
        push(EV_FETCH, 5, BASE + 64'd4, ST_FETCH);
        run("beq not taken", 1, I_BEQ, 0, 0, 1'b0, 64'h8000_0100, 1'b0);

        // jal to a misaligned target traps, PC held, no further fetch
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_ERR, 5, BASE, ST_ERR);
        run("jal misaligned", 1, I_JAL, 0, 0, 1'b0, 64'h8000_0002, 1'b0);

        // jalr aligned writes rd and redirects
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_RETIRE, 4, BASE, RET_WR);
        push(EV_FETCH, 5, 64'h8000_0010, ST_FETCH);
        run("jalr", 1, I_JALR, 0, 0, 1'b0, 64'h8000_0010, 1'b0);

        // fetch never acked: timeout after the count reaches 255
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_ERR, 257, BASE, ST_ERR);
        run("fetch timeout", 0, NOP, 0, 0, 1'b0, 64'h0, 1'b0);

        // ack exactly at count 255 still completes
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_RETIRE, 259, BASE, RET_WR);
        push(EV_FETCH, 260, BASE + 64'd4, ST_FETCH);
        run("ack at timeout", 1, I_ADDI, 255, 0, 1'b0, 64'h0, 1'b0);

        // ebreak halts after DECODE; ecall (bit 20 clear) retires without write
        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_HALT, 3, BASE, ST_HALT);
        run("ebreak", 1, I_EBREAK, 0, 0, 1'b0, 64'h0, 1'b0);

        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_RETIRE, 4, BASE, RET_NW);
        push(EV_FETCH, 5, BASE + 64'd4, ST_FETCH);
        run("ecall", 1, I_ECALL, 0, 0, 1'b0, 64'h0, 1'b0);

        // async reset mid-MEM, in the same cycle the dmem ack arrives
        plen = 1; prog0 = I_LD; iwait = 0; dwait = 2;
        br_taken_i = 1'b0; target_i = 64'h0; spur = 1'b0;
        push(EV_FETCH, 1, BASE, ST_FETCH);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        chk("mid-mem dmem_req", 64'(dmem_req_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("async rst ctl", 64'({imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, retire_o, halt_o, err_o}), 64'd0);
        chk("async rst pc", pc_o, BASE);
        chk("async rst inst", 64'(inst_o), 64'(NOP));
        chk("async rst state", 64'(state_o), ST_FETCH);
        drain("mid-mem first run", 1);

        push(EV_FETCH, 1, BASE, ST_FETCH);
        push(EV_DMEM, 7, 64'd3, 64'd0);
        push(EV_RETIRE, 7, BASE, RET_WR);
        push(EV_FETCH, 8, BASE + 64'd4, ST_FETCH);
        run("ld after reset", 1, I_LD, 0, 2, 1'b0, 64'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
